// File: rtl/dm_arbiter.sv
// Two-master arbiter for the single-port data memory: fixed priority with aging of the losing master,
// bad-address rejection and registered read return. Define DM_ARB_TRACE_EN to print a write/error trace.

module dm_arb_master #(
  parameter int AW       = 10,
  parameter int MAX_WAIT = 4,
  parameter bit AGE_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic        win,
  input  logic [31:0] dm_rdata,
  output logic        bad,
  output logic        ack,
  output logic        err,
  output logic [3:0]  wait_cnt,
  output logic        rvalid,
  output logic [31:0] rdata
);
  localparam logic [3:0] MW = 4'(MAX_WAIT);

  logic rvalid_q;

  assign bad = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
  assign ack = win & ~bad;
  assign err = win & bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      rvalid_q <= 1'b0;
      rdata    <= '0;
    end else begin
      // only the non-priority side ages; a win (ack or err) or a dropped req restarts the count
      if (!AGE_EN || !req || win)
        wait_cnt <= '0;
      else if (wait_cnt != MW)
        wait_cnt <= wait_cnt + 4'd1;
      rvalid_q <= ack & ~we;
      if (ack & ~we)
        rdata <= dm_rdata;
    end
  end

  // a pending read return is dropped in the reset cycle itself
  assign rvalid = rvalid_q & ~reset;
endmodule

module dm_arbiter #(
  parameter bit PRIO     = 1'b0,
  parameter int MAX_WAIT = 4,
  parameter int AW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic [AW-1:0] dm_idx,
  output logic [31:0]   dm_wdata,
  output logic          dm_we,
  input  logic [31:0]   dm_rdata
);
  localparam int         P  = PRIO ? 1 : 0;
  localparam int         NP = 1 - P;
  localparam logic [3:0] MW = 4'(MAX_WAIT);

  logic [1:0]        req, we, win, bad, ack, err, rvalid;
  logic [1:0][31:0]  addr, wdata, rdata;
  logic [1:0][3:0]   wait_cnt;

  assign req   = {m1_req, m0_req};
  assign we    = {m1_we, m0_we};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};

  always_comb begin
    win = '0;
    if (!reset) begin
      if (req[0] && req[1]) begin
        if (wait_cnt[NP] == MW) win[NP] = 1'b1;
        else                    win[P]  = 1'b1;
      end else begin
        win = req;
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_m
    dm_arb_master #(.AW(AW), .MAX_WAIT(MAX_WAIT), .AGE_EN(i != P)) u_m (
      .clk      (clk),
      .reset    (reset),
      .req      (req[i]),
      .we       (we[i]),
      .addr     (addr[i]),
      .win      (win[i]),
      .dm_rdata (dm_rdata),
      .bad      (bad[i]),
      .ack      (ack[i]),
      .err      (err[i]),
      .wait_cnt (wait_cnt[i]),
      .rvalid   (rvalid[i]),
      .rdata    (rdata[i])
    );
  end

  always_comb begin
    dm_idx   = '0;
    dm_wdata = '0;
    dm_we    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (win[i]) begin
        dm_idx   = addr[i][AW+1:2];
        dm_wdata = wdata[i];
        dm_we    = we[i] & ~bad[i];
      end
    end
  end

  assign m0_ack    = ack[0];
  assign m0_err    = err[0];
  assign m0_rvalid = rvalid[0];
  assign m0_rdata  = rdata[0];
  assign m1_ack    = ack[1];
  assign m1_err    = err[1];
  assign m1_rvalid = rvalid[1];
  assign m1_rdata  = rdata[1];

`ifdef DM_ARB_TRACE_EN
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (win[i] && dm_we) $display("%d@M%0d: *%h <= %h", $time, i, addr[i], wdata[i]);
      if (err[i])          $display("%d@M%0d: bad addr %h", $time, i, addr[i]);
    end
  end
`else
  // trace printing compiled out; datapath unchanged
`endif
endmodule
